// File: rtl/stim_sequencer_if.sv
// Signal bundle between the stimulus sequencer and its environment
// (control, stimulus RAM read port, DUT vector/response, status).
interface stim_sequencer_if;
  logic        start;
  logic        abort;
  logic [9:0]  length;
  logic        loop_en;
  logic [9:0]  mem_addr;
  logic [2:0]  mem_rdata;
  logic [2:0]  vec_out;
  logic        vec_valid;
  logic [5:0]  dut_out;
  logic [15:0] sig;
  logic [9:0]  vec_count;
  logic        busy;
  logic        done;

  // Environment side: drives control, RAM data and DUT response
  modport master (
    output start, abort, length, loop_en, mem_rdata, dut_out,
    input  mem_addr, vec_out, vec_valid, sig, vec_count, busy, done
  );

  // Sequencer side
  modport slave (
    input  start, abort, length, loop_en, mem_rdata, dut_out,
    output mem_addr, vec_out, vec_valid, sig, vec_count, busy, done
  );
endinterface

// File: rtl/stim_sequencer.sv
// Stimulus sequencer: walks a stimulus RAM from address 0 to length-1, applies each
// entry to the DUT as a registered vector, optionally loops, and compacts the DUT
// responses into a 16-bit MISR signature.
//
// RAM timing: mem_rdata reflects ram[mem_addr] in the cycle after mem_addr is
// registered, so the vector for the current address is loaded on every step edge
// (including the edge leaving FETCH) while mem_addr advances in the same edge.
module stim_sequencer (
  input logic             clock,
  input logic             reset,
  stim_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StRun, StDone} state_e;

  state_e     state;
  state_e     state_next;
  logic [9:0] len;
  // Final vector of a non-looping pass has been loaded; next edge ends the run
  logic       drain;
  logic       running;
  logic       accept;
  logic       stop;
  logic       step;
  logic       at_end;
  logic       fb;

  assign running = (state == StFetch) || (state == StRun);
  assign accept  = (state == StIdle) && bus.start && !bus.abort;
  assign stop    = running && (bus.abort || ((state == StRun) && drain));
  assign step    = running && !stop;
  assign at_end  = (bus.mem_addr == (len - 10'd1));
  assign fb      = bus.sig[15] ^ bus.sig[13] ^ bus.sig[12] ^ bus.sig[10];

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= StIdle;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      StIdle: begin
        if (accept) begin
          state_next = (bus.length == 10'd0) ? StDone : StFetch;
        end
      end
      StFetch, StRun: state_next = stop ? StDone : StRun;
      StDone:         state_next = StIdle;
      default:        state_next = StIdle;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    bus.busy = running;
    bus.done = (state == StDone);
  end

  // Address generation, vector register and per-pass vector count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len           <= 10'd0;
      drain         <= 1'b0;
      bus.mem_addr  <= 10'd0;
      bus.vec_out   <= 3'd0;
      bus.vec_valid <= 1'b0;
      bus.vec_count <= 10'd0;
    end else begin
      if (accept) begin
        len           <= bus.length;
        drain         <= 1'b0;
        bus.mem_addr  <= 10'd0;
        bus.vec_count <= 10'd0;
      end
      if (stop) begin
        bus.vec_out   <= 3'd0;
        bus.vec_valid <= 1'b0;
      end
      if (step) begin
        bus.vec_out   <= bus.mem_rdata;
        bus.vec_valid <= 1'b1;
        // Address 0 starts a pass, so the count restarts there
        bus.vec_count <= (bus.mem_addr == 10'd0) ? 10'd1 : bus.vec_count + 10'd1;
        if (at_end) begin
          if (bus.loop_en) begin
            bus.mem_addr <= 10'd0;
          end else begin
            drain <= 1'b1;
          end
        end else begin
          bus.mem_addr <= bus.mem_addr + 10'd1;
        end
      end
      if (state == StDone) begin
        drain <= 1'b0;
      end
    end
  end

  // MISR: absorbs the DUT response to every applied vector
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.sig <= 16'd0;
    end else if (accept) begin
      bus.sig <= 16'd0;
    end else if (bus.vec_valid) begin
      bus.sig <= {bus.sig[14:0], fb} ^ {10'b0, bus.dut_out};
    end
  end

endmodule

// File: doc/stim_sequencer.md
STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 The module SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have port start, input, 1 bit: request a run; sampled only in IDLE.
REQ-004 The module SHALL have port abort, input, 1 bit: terminate the current run.
REQ-005 The module SHALL have port length, input, 10 bits: number of vectors per pass, 0..1000; captured when start is accepted.
REQ-006 The module SHALL have port loop_en, input, 1 bit: repeat the pass continuously.
REQ-007 The module SHALL have port mem_addr, output, 10 bits: registered read address to the stimulus RAM.
REQ-008 The module SHALL have port mem_rdata, input, 3 bits: RAM data; ram[A] is valid in the cycle after the edge that samples mem_addr=A.
REQ-009 The module SHALL have port vec_out, output, 3 bits: registered vector to the DUT ({__obs, cont_eql, eql}).
REQ-010 The module SHALL have port vec_valid, output, 1 bit: vec_out holds an applied vector.
REQ-011 The module SHALL have port dut_out, input, 6 bits: DUT response ({cc_mux, uscite, enable_count, ackout}).
REQ-012 The module SHALL have port sig, output, 16 bits: MISR signature of DUT responses.
REQ-013 The module SHALL have port vec_count, output, 10 bits: vectors applied in the current pass.
REQ-014 The module SHALL have port busy, output, 1 bit: high in FETCH and RUN.
REQ-015 The module SHALL have port done, output, 1 bit: one-cycle pulse in DONE.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, RUN and DONE.
REQ-017 In IDLE, start=1 with abort=0 SHALL be accepted: length is latched, sig and vec_count are cleared, mem_addr is set to 0, and the next state is FETCH, or DONE if length=0.
REQ-018 In IDLE, start=1 with abort=1 SHALL be ignored.
REQ-019 start SHALL be ignored in every state except IDLE.
REQ-020 FETCH SHALL last exactly one cycle: mem_addr becomes 1 (0 if length=1), then the next state is RUN.
REQ-021 In RUN, each edge SHALL load vec_out with mem_rdata, set vec_valid=1, increment vec_count, and advance mem_addr.
REQ-022 Latency: the first vector SHALL appear on vec_out two cycles after the edge that accepts start.
REQ-023 When mem_addr has issued length-1, loop_en SHALL be sampled.
REQ-024 If the sampled loop_en is 1, mem_addr SHALL wrap to 0 on the next edge with no bubble on vec_valid, and vec_count SHALL restart at 1 on the first vector of the new pass.
REQ-025 If the sampled loop_en is 0, mem_addr SHALL hold, and the edge after the last vector is applied SHALL enter DONE with vec_valid=0 and vec_out=0.
REQ-026 abort=1 in FETCH or RUN SHALL cause the next edge to enter DONE with vec_valid=0, vec_out=0, and mem_addr held.
REQ-027 abort SHALL have no effect in DONE.
REQ-028 DONE SHALL last one cycle with done=1, then the next state is IDLE.
REQ-029 vec_count and sig SHALL hold their values in DONE and IDLE until the next start is accepted.
REQ-030 MISR: on every edge where vec_valid=1, sig SHALL update as sig <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} XOR {10'b0, dut_out}.
REQ-031 sig SHALL hold when vec_valid=0.
REQ-032 mem_addr arithmetic SHALL be 10-bit, and the address SHALL never exceed length-1.

Reset
REQ-033 reset=0 SHALL asynchronously force state=IDLE, mem_addr=0, vec_out=0, vec_valid=0, sig=0, vec_count=0, busy=0 and done=0, including mid-run.
REQ-034 After reset deasserts, no vector SHALL be applied until a new start is accepted.

Verification
REQ-035 Scenario: ram={001,110,101}, length=3, loop_en=0, start at edge 0 -> vec_out=001/110/101 with vec_valid in cycles 2/3/4; done=1 in cycle 5; busy=1 in cycles 1-4; vec_count=3.
REQ-036 Scenario: length=2, loop_en=1, ram={011,100} -> vec_out alternates 011,100,011,... with no vec_valid gap; clearing loop_en ends the run after the current pass completes, then a done pulse.
REQ-037 Scenario: abort in the third RUN cycle -> vec_valid=0 on the next cycle, done pulse, vec_count=2; a simultaneous start+abort in IDLE -> busy stays 0.
REQ-038 Scenario: length=0, start -> done=1 in cycle 1; vec_valid never asserts; sig=0.
REQ-039 Scenario: dut_out=6'h00 for all vectors -> sig=16'h0000; dut_out=6'h01 on the first vector only, length=1 -> sig=16'h0001.
REQ-040 Scenario: reset pulsed low asynchronously mid-RUN (between edges) -> all outputs are 0 immediately; a subsequent start replays from address 0.
